// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: port identifiers,
// statistics counter width and the legal read-latency range.
package ram_arb_pkg;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_t;

    localparam int CNT_W      = 16;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    // The port that gets priority after the given port has been served.
    function automatic port_id_t other_port(input port_id_t p);
        return (p == PORT0) ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/ram_arb_tag_pipe.sv
// Read-return tag pipeline: carries the requesting port ID of each issued
// read for RD_LAT cycles so the returning RAM data can be steered.
module ram_arb_tag_pipe
    import ram_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic     sys_clk,
    input  logic     rst_n,
    input  logic     push_valid,
    input  port_id_t push_port,
    output logic     pop_valid,
    output port_id_t pop_port
);

    if ((RD_LAT < RD_LAT_MIN) || (RD_LAT > RD_LAT_MAX)) begin : g_bad_lat
        $error("ram_arb_tag_pipe: RD_LAT out of range");
    end

    logic [RD_LAT-1:0] valid_r;
    port_id_t          port_r [RD_LAT];

    // Shift read tags one stage per cycle; reset drops everything in flight.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {RD_LAT{1'b0}};
            for (int i = 0; i < RD_LAT; i++) begin
                port_r[i] <= PORT0;
            end
        end else begin
            valid_r[0] <= push_valid;
            port_r[0]  <= push_port;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_r[i] <= valid_r[i-1];
                port_r[i]  <= port_r[i-1];
            end
        end
    end

    assign pop_valid = valid_r[RD_LAT-1];
    assign pop_port  = port_r[RD_LAT-1];

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// Optional per-port accept counters are built when RAM_ARB_STATS_EN is
// defined; otherwise m0_cnt/m1_cnt are tied to zero.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [CNT_W-1:0]  m0_cnt,
    output logic [CNT_W-1:0]  m1_cnt
);

    port_id_t ptr_r;
    port_id_t issued_port_r;
    logic     grant0_s;
    logic     grant1_s;
    logic     xfer_s;
    port_id_t grant_port_s;
    logic     tag_valid_s;
    port_id_t tag_port_s;

    // Round-robin grant: a lone requester wins, ties go to the pointer port.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (!rst_n) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (m0_req && (!m1_req || (ptr_r == PORT0))) begin
            grant0_s = 1'b1;
        end else if (m1_req) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign m0_ack       = grant0_s;
    assign m1_ack       = grant1_s;
    assign xfer_s       = grant0_s | grant1_s;
    assign grant_port_s = grant1_s ? PORT1 : PORT0;

    // Register the granted command toward the RAM and advance the pointer.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r         <= PORT0;
            issued_port_r <= PORT0;
            ram_en        <= 1'b0;
            ram_we        <= 1'b0;
            ram_addr      <= {ADDR_W{1'b0}};
            ram_wdata     <= {DATA_W{1'b0}};
        end else begin
            ram_en <= xfer_s;
            if (xfer_s) begin
                ram_we        <= grant1_s ? m1_we    : m0_we;
                ram_addr      <= grant1_s ? m1_addr  : m0_addr;
                ram_wdata     <= grant1_s ? m1_wdata : m0_wdata;
                issued_port_r <= grant_port_s;
                ptr_r         <= other_port(grant_port_s);
            end else begin
                ram_we <= 1'b0;
            end
        end
    end

    ram_arb_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .push_valid (ram_en & ~ram_we),
        .push_port  (issued_port_r),
        .pop_valid  (tag_valid_s),
        .pop_port   (tag_port_s)
    );

    // Steer the returning RAM word to the port that issued the read.
    always_comb begin
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        m0_rdata  = {DATA_W{1'b0}};
        m1_rdata  = {DATA_W{1'b0}};
        if (tag_valid_s && (tag_port_s == PORT0)) begin
            m0_rvalid = 1'b1;
            m0_rdata  = ram_rdata;
        end else if (tag_valid_s) begin
            m1_rvalid = 1'b1;
            m1_rdata  = ram_rdata;
        end else begin
            m0_rvalid = 1'b0;
            m1_rvalid = 1'b0;
        end
    end

`ifdef RAM_ARB_STATS_EN
    logic [CNT_W-1:0] m0_cnt_r;
    logic [CNT_W-1:0] m1_cnt_r;

    // Count accepted commands per port; wraps naturally at 2**CNT_W.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_cnt_r <= {CNT_W{1'b0}};
            m1_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (grant0_s) begin
                m0_cnt_r <= m0_cnt_r + CNT_W'(1);
            end
            if (grant1_s) begin
                m1_cnt_r <= m1_cnt_r + CNT_W'(1);
            end
        end
    end

    assign m0_cnt = m0_cnt_r;
    assign m1_cnt = m1_cnt_r;
`else
    assign m0_cnt = {CNT_W{1'b0}};
    assign m1_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: three DUT copies (RD_LAT = 1, 2, 3) share one
// stimulus stream; each has its own behavioural RAM. A reference model of
// the round-robin rule, a RAM content array and per-latency queues of
// expected read returns predict every output cycle by cycle.
`timescale 1ns/1ps
module tb_ram_arbiter;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam int NL = 3;
`ifdef RAM_ARB_STATS_EN
    localparam logic [15:0] STATS_MASK = 16'hFFFF;
    localparam int          WRAP_N     = 65535;
`else
    localparam logic [15:0] STATS_MASK = 16'h0000;
    localparam int          WRAP_N     = 300;
`endif

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
        logic [31:0]   due;
    } rd_exp_t;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic          m0_req, m1_req, m0_we, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;

    logic [NL-1:0] m0_ack_a, m1_ack_a, m0_rvalid_a, m1_rvalid_a, ram_en_a, ram_we_a;
    logic [DW-1:0] m0_rdata_a [NL];
    logic [DW-1:0] m1_rdata_a [NL];
    logic [DW-1:0] ram_wdata_a [NL];
    logic [DW-1:0] ram_rdata_a [NL];
    logic [AW-1:0] ram_addr_a [NL];
    logic [15:0]   m0_cnt_a [NL];
    logic [15:0]   m1_cnt_a [NL];

    for (genvar g = 0; g < NL; g++) begin : g_lat
        logic [DW-1:0] mem [2**AW] = '{default: '0};
        logic [DW-1:0] rd_pipe [g+1];

        ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(g+1)) dut (
            .sys_clk   (sys_clk),
            .rst_n     (rst_n),
            .m0_req    (m0_req),
            .m0_we     (m0_we),
            .m0_addr   (m0_addr),
            .m0_wdata  (m0_wdata),
            .m0_ack    (m0_ack_a[g]),
            .m0_rvalid (m0_rvalid_a[g]),
            .m0_rdata  (m0_rdata_a[g]),
            .m1_req    (m1_req),
            .m1_we     (m1_we),
            .m1_addr   (m1_addr),
            .m1_wdata  (m1_wdata),
            .m1_ack    (m1_ack_a[g]),
            .m1_rvalid (m1_rvalid_a[g]),
            .m1_rdata  (m1_rdata_a[g]),
            .ram_en    (ram_en_a[g]),
            .ram_we    (ram_we_a[g]),
            .ram_addr  (ram_addr_a[g]),
            .ram_wdata (ram_wdata_a[g]),
            .ram_rdata (ram_rdata_a[g]),
            .m0_cnt    (m0_cnt_a[g]),
            .m1_cnt    (m1_cnt_a[g])
        );

        // Single-port RAM with g+1 cycles of read latency.
        always @(posedge sys_clk) begin
            if (ram_en_a[g] && ram_we_a[g]) mem[ram_addr_a[g]] <= ram_wdata_a[g];
            rd_pipe[0] <= (ram_en_a[g] && !ram_we_a[g]) ? mem[ram_addr_a[g]] : 16'hBAD0;
            for (int i = 1; i <= g; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
        assign ram_rdata_a[g] = rd_pipe[g];
    end

    // Reference model state
    logic [DW-1:0] model_mem [2**AW] = '{default: '0};
    rd_exp_t       exp_q [NL][$];
    logic          prefer1;
    logic          gm0, gm1;
    logic          prev_xfer, prev_we;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_wdata;
    logic [15:0]   cnt0, cnt1;
    int            cyc;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s lat%0d observed=%0h expected=%0h", tag, k + 1, obs, exp);
        end
    endtask

    task automatic cycle_check();
        rd_exp_t e;
        logic ex0, ex1, port;
        logic [DW-1:0] exd;
        gm0 = rst_n & m0_req & (!m1_req | !prefer1);
        gm1 = rst_n & m1_req & !gm0;
        for (int k = 0; k < NL; k++) begin
            chk("ram_en", k, 32'(ram_en_a[k]), 32'(prev_xfer));
            chk("ram_we", k, 32'(ram_we_a[k]), 32'(prev_xfer & prev_we));
            if (prev_xfer) begin
                chk("ram_addr", k, 32'(ram_addr_a[k]), 32'(prev_addr));
                chk("ram_wdata", k, 32'(ram_wdata_a[k]), 32'(prev_wdata));
            end
            ex0 = 1'b0; ex1 = 1'b0; exd = '0;
            if (exp_q[k].size() != 0 && exp_q[k][0].due == 32'(cyc)) begin
                e   = exp_q[k].pop_front();
                ex0 = !e.port;
                ex1 = e.port;
                exd = e.data;
            end
            chk("m0_rvalid", k, 32'(m0_rvalid_a[k]), 32'(ex0));
            chk("m1_rvalid", k, 32'(m1_rvalid_a[k]), 32'(ex1));
            if (ex0) chk("m0_rdata", k, 32'(m0_rdata_a[k]), 32'(exd));
            if (ex1) chk("m1_rdata", k, 32'(m1_rdata_a[k]), 32'(exd));
            chk("m0_cnt", k, 32'(m0_cnt_a[k]), 32'(cnt0 & STATS_MASK));
            chk("m1_cnt", k, 32'(m1_cnt_a[k]), 32'(cnt1 & STATS_MASK));
            chk("m0_ack", k, 32'(m0_ack_a[k]), 32'(gm0));
            chk("m1_ack", k, 32'(m1_ack_a[k]), 32'(gm1));
            chk("ack_onehot", k, 32'(m0_ack_a[k] & m1_ack_a[k]), 32'(0));
        end
        prev_xfer = gm0 | gm1;
        if (gm0 | gm1) begin
            port       = gm1;
            prev_we    = port ? m1_we    : m0_we;
            prev_addr  = port ? m1_addr  : m0_addr;
            prev_wdata = port ? m1_wdata : m0_wdata;
            if (prev_we) begin
                model_mem[prev_addr] = prev_wdata;
            end else begin
                for (int k = 0; k < NL; k++)
                    exp_q[k].push_back('{port: port, data: model_mem[prev_addr], due: 32'(cyc + 2 + k)});
            end
            if (port) cnt1 = cnt1 + 16'd1;
            else      cnt0 = cnt0 + 16'd1;
            prefer1 = !port;
        end
    endtask

    task automatic step();
        #1;
        cycle_check();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
    endtask

    // One cycle of reset with both ports requesting; everything must read zero.
    task automatic apply_reset();
        rst_n = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1;
        #1;
        for (int k = 0; k < NL; k++) begin
            chk("rst_m0_ack", k, 32'(m0_ack_a[k]), 32'(0));
            chk("rst_m1_ack", k, 32'(m1_ack_a[k]), 32'(0));
            chk("rst_ram_en", k, 32'(ram_en_a[k]), 32'(0));
            chk("rst_ram_we", k, 32'(ram_we_a[k]), 32'(0));
            chk("rst_ram_addr", k, 32'(ram_addr_a[k]), 32'(0));
            chk("rst_ram_wdata", k, 32'(ram_wdata_a[k]), 32'(0));
            chk("rst_rvalid", k, 32'({m0_rvalid_a[k], m1_rvalid_a[k]}), 32'(0));
            chk("rst_m0_rdata", k, 32'(m0_rdata_a[k]), 32'(0));
            chk("rst_m1_rdata", k, 32'(m1_rdata_a[k]), 32'(0));
            chk("rst_m0_cnt", k, 32'(m0_cnt_a[k]), 32'(0));
            chk("rst_m1_cnt", k, 32'(m1_cnt_a[k]), 32'(0));
            exp_q[k].delete();
        end
        prefer1 = 1'b0; prev_xfer = 1'b0; prev_we = 1'b0;
        cnt0 = 16'd0; cnt1 = 16'd0;
        @(posedge sys_clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    initial begin
        cyc = 0;
        prev_addr = '0; prev_wdata = '0;
        set_m0(1'b0, 1'b0, 9'h000, 16'h0000);
        set_m1(1'b0, 1'b0, 9'h000, 16'h0000);
        @(posedge sys_clk);
        #1;
        apply_reset();

        // Single port: write then read back 0x010
        set_m0(1'b1, 1'b1, 9'h010, 16'hA5A5);
        step();
        set_m0(1'b1, 1'b0, 9'h010, 16'h0000);
        step();
        m0_req = 1'b0;
        repeat (5) step();

        // Both ports requesting continuously from reset: strict alternation
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            set_m0(1'b1, 1'b1, AW'(9'h100 + i), DW'(16'h1000 + i));
            set_m1(1'b1, 1'b1, AW'(9'h180 + i), DW'(16'h2000 + i));
            #1;
            chk("alternate", 0, 32'(m0_ack_a[0]), 32'(i % 2 == 0));
            step();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        #1;
        chk("m0_cnt_after8", 0, 32'(m0_cnt_a[0]), 32'(16'd4 & STATS_MASK));
        chk("m1_cnt_after8", 0, 32'(m1_cnt_a[0]), 32'(16'd4 & STATS_MASK));
        step();

        // Back-to-back reads from both ports after preloading two words
        set_m0(1'b1, 1'b1, 9'h001, 16'h1111);
        step();
        m0_req = 1'b0;
        set_m1(1'b1, 1'b1, 9'h002, 16'h2222);
        step();
        set_m0(1'b1, 1'b0, 9'h001, 16'h0000);
        set_m1(1'b1, 1'b0, 9'h002, 16'h0000);
        step();
        if (gm0) m0_req = 1'b0;
        if (gm1) m1_req = 1'b0;
        step();
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (5) step();

        // Reset with two reads in flight: nothing may come back afterwards
        set_m0(1'b1, 1'b0, 9'h001, 16'h0000);
        step();
        m0_req = 1'b0;
        set_m1(1'b1, 1'b0, 9'h002, 16'h0000);
        step();
        apply_reset();
        repeat (5) step();
        set_m0(1'b1, 1'b0, 9'h003, 16'h0000);
        set_m1(1'b1, 1'b0, 9'h004, 16'h0000);
        #1;
        chk("first_ack_after_reset", 0, 32'({m0_ack_a[0], m1_ack_a[0]}), 32'(2'b10));
        step();
        m0_req = 1'b0;
        step();
        m1_req = 1'b0;
        repeat (5) step();

        // Counter wrap on port 1 (stays zero without statistics)
        apply_reset();
        for (int i = 0; i < WRAP_N; i++) begin
            set_m1(1'b1, 1'b1, AW'($urandom_range(0, 31)), DW'($urandom));
            step();
        end
        m1_req = 1'b0;
        #1;
        chk("m1_cnt_pre_wrap", 0, 32'(m1_cnt_a[0]), 32'(16'hFFFF & STATS_MASK));
        set_m1(1'b1, 1'b1, 9'h01F, 16'h5A5A);
        step();
        m1_req = 1'b0;
        #1;
        chk("m1_cnt_wrapped", 0, 32'(m1_cnt_a[0]), 32'(16'h0000));
        step();

        // Random mixed traffic; requests hold until accepted
        gm0 = 1'b0; gm1 = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!m0_req || gm0)
                set_m0($urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
            if (!m1_req || gm1)
                set_m1($urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
            step();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (6) step();
        for (int k = 0; k < NL; k++)
            chk("reads_drained", k, 32'(exp_q[k].size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
